// File: rtl/dbg_capture_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbg_capture_ctrl_pkg
// Description : Shared types and helpers for the debug capture controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dbg_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4,
    READ  = 3'd5
  } dbg_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int f_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dbg_skid_fifo
// Description : Two-entry valid/ready FIFO; output data held stable while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_idx;
  logic             r_rd_idx;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rd_idx];
  assign count     = r_count;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_idx] <= in_data;
        r_wr_idx        <= ~r_wr_idx;
      end
      if (w_pop) r_rd_idx <= ~r_rd_idx;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dbg_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dbg_capture_ctrl
// Description : Rolling-window debug capture into a dual-port RAM, stop after
//               trigger, chronological readout over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_capture_ctrl
  import dbg_capture_ctrl_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 1024,
  parameter  int PRE_TRIG = 256,
  localparam int AWIDTH   = f_log2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_in,
  input  logic [WIDTH-1:0]  smp_in,
  input  logic              rd_start,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_wr_addr,
  output logic [WIDTH-1:0]  ram_din,
  output logic              ram_re,
  output logic [AWIDTH-1:0] ram_rd_addr,
  input  logic [WIDTH-1:0]  ram_dout,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] trig_addr
);

  localparam logic [AWIDTH-1:0] c_pre_trig  = AWIDTH'(PRE_TRIG);
  localparam logic [AWIDTH-1:0] c_pre_last  = AWIDTH'(PRE_TRIG - 1);
  localparam logic [AWIDTH-1:0] c_post_last = AWIDTH'(DEPTH - PRE_TRIG - 2);
  localparam logic [AWIDTH-1:0] c_last_beat = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH:0]   c_depth     = (AWIDTH + 1)'(DEPTH);

  dbg_state_e        r_state;
  dbg_state_e        w_state_nxt;
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_pre_cnt;
  logic [AWIDTH-1:0] r_post_cnt;
  logic [AWIDTH-1:0] r_trig_addr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_issued;
  logic [AWIDTH-1:0] r_beat_cnt;
  logic              r_ram_we;
  logic [AWIDTH-1:0] r_ram_wr_addr;
  logic [WIDTH-1:0]  r_ram_din;
  logic              r_dv;

  logic              w_start;
  logic              w_capture;
  logic              w_trig_hit;
  logic              w_rd_go;
  logic              w_ram_re;
  logic              w_pop;
  logic              w_credit;
  logic [2:0]        w_occ;
  logic [1:0]        w_skid_count;
  logic              w_skid_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_trig_hit  = 1'b0;
    w_rd_go     = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (arm) begin
            w_start     = 1'b1;
            w_state_nxt = (PRE_TRIG == 0) ? ARMED : PRE;
          end
        end
        PRE: begin
          w_capture = 1'b1;
          if (r_pre_cnt == c_pre_last) w_state_nxt = ARMED;
        end
        ARMED: begin
          w_capture = 1'b1;
          if (trig_in) begin
            w_trig_hit  = 1'b1;
            w_state_nxt = (PRE_TRIG == DEPTH - 1) ? DONE : POST;
          end
        end
        POST: begin
          w_capture = 1'b1;
          if (r_post_cnt == c_post_last) w_state_nxt = DONE;
        end
        DONE: begin
          if (arm) begin
            w_start     = 1'b1;
            w_state_nxt = (PRE_TRIG == 0) ? ARMED : PRE;
          end else if (rd_start) begin
            w_rd_go     = 1'b1;
            w_state_nxt = READ;
          end
        end
        READ: begin
          if (w_pop && out_last) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Credit counts the beat leaving this cycle so one read per cycle can be
  // sustained while skid entries plus the read in flight never exceed two.
  assign w_pop    = out_valid & out_ready;
  assign w_occ    = {1'b0, w_skid_count} + {2'b00, r_dv} - {2'b00, w_pop};
  assign w_credit = (w_occ < 3'd2);
  assign w_ram_re = (r_state == READ) && (r_issued != c_depth) && w_credit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_pre_cnt     <= '0;
      r_post_cnt    <= '0;
      r_trig_addr   <= '0;
      r_rd_ptr      <= '0;
      r_issued      <= '0;
      r_beat_cnt    <= '0;
      r_ram_we      <= 1'b0;
      r_ram_wr_addr <= '0;
      r_ram_din     <= '0;
      r_dv          <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ram_we <= w_capture;
      r_dv     <= w_ram_re & ~abort;
      if (w_capture) begin
        r_ram_wr_addr <= r_wr_ptr;
        r_ram_din     <= smp_in;
      end
      if (w_start) begin
        r_wr_ptr  <= '0;
        r_pre_cnt <= '0;
      end else if (w_capture) begin
        r_wr_ptr  <= r_wr_ptr + AWIDTH'(1);
        r_pre_cnt <= r_pre_cnt + AWIDTH'(1);
      end
      if (w_trig_hit) begin
        r_trig_addr <= r_wr_ptr;
        r_post_cnt  <= '0;
      end else if (w_capture) begin
        r_post_cnt <= r_post_cnt + AWIDTH'(1);
      end
      if (w_rd_go) begin
        r_rd_ptr   <= r_trig_addr - c_pre_trig;
        r_issued   <= '0;
        r_beat_cnt <= '0;
      end else begin
        if (w_ram_re) begin
          r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
          r_issued <= r_issued + (AWIDTH + 1)'(1);
        end
        if (w_pop) r_beat_cnt <= r_beat_cnt + AWIDTH'(1);
      end
    end
  end

  dbg_skid_fifo #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (abort),
    .in_valid  (r_dv),
    .in_ready  (w_skid_in_ready),
    .in_data   (ram_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (w_skid_count)
  );

  assign ram_we      = r_ram_we;
  assign ram_wr_addr = r_ram_wr_addr;
  assign ram_din     = r_ram_din;
  assign ram_re      = w_ram_re;
  assign ram_rd_addr = r_rd_ptr;
  assign out_last    = out_valid && (r_beat_cnt == c_last_beat);
  assign busy        = (r_state == PRE) || (r_state == ARMED) ||
                       (r_state == POST) || (r_state == READ);
  assign done        = (r_state == DONE);
  assign trig_addr   = r_trig_addr;

endmodule
`default_nettype wire

// File: doc/dbg_capture_ctrl.md
Name: dbg_capture_ctrl

Overview:
- Capture controller that sits directly upstream of the debug dual-port block RAM.
- Writes a rolling window of sampled debug data into the RAM, stops a fixed number of samples after a trigger, then streams the window back in chronological order over a valid/ready port.
- Drives both RAM ports from a single clock. The RAM is instantiated with OUT_REG="EN", so read data arrives 1 cycle after ram_re and reads 0 when ram_re was low.

Parameters:
- WIDTH, 32: sample width in bits.
- DEPTH, 1024: RAM depth in samples; must be a power of 2, ≥4.
- PRE_TRIG, 256: samples kept before the trigger sample; range 0..DEPTH-1.
- AWIDTH, log2(DEPTH): localparam, computed with the shared math include.

Ports:
- clk  in  1  sole clock; also connected to the RAM wr_clk and rd_clk.
- resetn  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle start-capture pulse.
- abort  in  1  single-cycle return to IDLE from any state.
- trig_in  in  1  trigger qualifier, sampled with smp_in.
- smp_in  in  WIDTH  sample captured every cycle while capturing.
- rd_start  in  1  single-cycle start-readout pulse; honoured in DONE only.
- ram_we  out  1  RAM write enable.
- ram_wr_addr  out  AWIDTH  RAM write address.
- ram_din  out  WIDTH  RAM write data.
- ram_re  out  1  RAM read enable.
- ram_rd_addr  out  AWIDTH  RAM read address.
- ram_dout  in  WIDTH  RAM registered read data.
- out_data  out  WIDTH  readout sample.
- out_valid  out  1  readout data valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  high with the final (DEPTH-th) readout sample.
- busy  out  1  high in PRE, ARMED, POST and READ.
- done  out  1  high in DONE.
- trig_addr  out  AWIDTH  RAM address holding the trigger sample.

Behaviour:
- Reset: state=IDLE; all outputs 0; wr_ptr=0; internal counters 0; skid buffer empty.
- ram_we, ram_wr_addr and ram_din are registered: one cycle after smp_in is presented, they carry that sample and its address.
- IDLE:
  - arm → PRE; wr_ptr=0, pre_cnt=0.
  - trig_in is ignored.
- PRE:
  - Writes smp_in at wr_ptr every cycle; wr_ptr increments mod DEPTH; pre_cnt increments.
  - trig_in is ignored.
  - When pre_cnt reaches PRE_TRIG → ARMED. With PRE_TRIG=0, arm goes straight to ARMED.
- ARMED:
  - Writes every cycle; wr_ptr wraps freely.
  - The first cycle with trig_in=1 writes that sample, latches trig_addr=wr_ptr, sets post_cnt=0 and goes to POST.
- POST:
  - Writes DEPTH-PRE_TRIG-1 further samples, then → DONE.
  - With PRE_TRIG=DEPTH-1, the trigger cycle goes directly to DONE.
  - Total samples kept after and including the trigger = DEPTH-PRE_TRIG.
- DONE:
  - No writes; done=1.
  - rd_start → READ; rd_ptr=(trig_addr-PRE_TRIG) mod DEPTH, AWIDTH-bit wrap; issue count=0.
  - arm in DONE restarts a capture (→ PRE), discarding the held capture.
- READ:
  - Issues ram_re with ram_rd_addr=rd_ptr, then rd_ptr++ mod DEPTH, while issued<DEPTH and (skid_count + inflight) < 2.
  - ram_dout is taken 1 cycle after ram_re into a 2-entry skid FIFO that drives out_data and out_valid.
  - A beat transfers when out_valid and out_ready are both high.
  - out_data must hold stable while out_valid=1 and out_ready=0.
  - out_last is high on the DEPTH-th beat. When that beat is accepted → IDLE; done=0.
  - Sustains 1 beat/cycle when out_ready is held high.
- arm and rd_start are ignored outside the states named above.
- abort has priority over every other input in all states:
  - next state IDLE; ram_we=0 and ram_re=0 from the next edge;
  - skid flushed; out_valid=0; done=0; trig_addr retained.
- Reset asserted mid-operation: outputs clear asynchronously. RAM contents are undefined to the user afterwards.
- A trigger in the same cycle PRE finishes is ignored; the pre-trigger window is guaranteed full.

Decomposition:
- Shared debug package holds:
  - state encoding constants: IDLE, PRE, ARMED, POST, DONE, READ;
  - the log2 function from the math include.
- One sub-module, dbg_skid_fifo: parameter WIDTH, 2 entries, valid/ready on both sides, asynchronous active-low reset.
- The capture FSM and address counters stay in dbg_capture_ctrl.

Test Plan:
- Basic capture and readout:
  - Stimulus: DEPTH=16, PRE_TRIG=4, smp_in = cycle count; arm; trig_in at sample 10.
  - Required: trig_addr=10, done after 11 more writes; readout yields samples 6..21 in order, out_last on the 16th, then IDLE.
- Wrap-around:
  - Stimulus: DEPTH=16, PRE_TRIG=4, trigger at sample 40.
  - Required: trig_addr=8; first readout address 4; data 36..51.
- Trigger during PRE:
  - Stimulus: trig_in high from arm onward.
  - Required: the trigger is taken at sample 4 (the first ARMED cycle), not before; trig_addr=4.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1 repeating.
  - Required: no lost or duplicated beats; out_data stable while stalled; skid + inflight never exceeds 2.
- Abort mid-POST and mid-READ:
  - Required: ram_we/ram_re low next cycle; out_valid=0; busy=0.
  - A following arm captures normally.
- Reset mid-capture and boundaries:
  - Stimulus: resetn low for 1 cycle mid-POST.
  - Required: all outputs 0 immediately; state IDLE.
  - PRE_TRIG=0: the trigger sample is the first beat of readout.
  - PRE_TRIG=DEPTH-1: the trigger sample is the last beat of readout.
